// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access controller: op codes, bus
// polarities and FSM states.
package mem_access_unit_pkg;

  // Codes 1 and 2 keep the legacy word-only encodings.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDW  = 4'd1,
    OP_STW  = 4'd2,
    OP_LDB  = 4'd3,
    OP_LDBU = 4'd4,
    OP_LDH  = 4'd5,
    OP_LDHU = 4'd6,
    OP_STB  = 4'd7,
    OP_STH  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: op decode, misalignment check, store lane
// replication with byte enables, and load lane select with extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic [3:0]        op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              is_mem,
  output logic              is_load,
  output logic              misaligned,
  output logic [BE_W-1:0]   be_,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ld_data
);

  acc_size_e         size;
  logic              sext;
  logic              sign_bit;
  logic              bad_off;
  logic [BE_W-1:0]   be_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;

  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b0;
    sext    = 1'b0;
    size    = SZ_WORD;
    case (op)
      OP_LDB:  begin is_load = 1'b1; size = SZ_BYTE; sext = 1'b1; end
      OP_LDBU: begin is_load = 1'b1; size = SZ_BYTE; end
      OP_LDH:  begin is_load = 1'b1; size = SZ_HALF; sext = 1'b1; end
      OP_LDHU: begin is_load = 1'b1; size = SZ_HALF; end
      OP_LDW:  is_load = 1'b1;
      OP_STB:  size = SZ_BYTE;
      OP_STH:  size = SZ_HALF;
      OP_STW:  size = SZ_WORD;
      default: is_mem = 1'b0;
    endcase
  end

  // Shifting the read data down by the byte offset puts the addressed lane at bit 0.
  always_comb begin
    shifted   = rd_data >> {offset, 3'b000};
    keep_mask = DATA_W'(32'hFFFF_FFFF);
    sign_bit  = 1'b0;
    wr_data   = st_data;
    be_mask   = BE_W'(4'hF) << offset;
    bad_off   = |offset[1:0];
    case (size)
      SZ_BYTE: begin
        keep_mask = DATA_W'(8'hFF);
        sign_bit  = shifted[7];
        wr_data   = {BE_W{st_data[7:0]}};
        be_mask   = BE_W'(1'b1) << offset;
        bad_off   = 1'b0;
      end
      SZ_HALF: begin
        keep_mask = DATA_W'(16'hFFFF);
        sign_bit  = shifted[15];
        wr_data   = {(BE_W/2){st_data[15:0]}};
        be_mask   = BE_W'(2'b11) << offset;
        bad_off   = offset[0];
      end
      default: begin
        wr_data = {(BE_W/4){st_data[31:0]}};
      end
    endcase
    misaligned = is_mem & bad_off;
    be_        = ~be_mask;
    ld_data    = (shifted & keep_mask) | ((sext & sign_bit) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller with wait-state bus handshake and MEM/WB result
// register. Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access outstanding; passthrough or accept a new request
// BUS   | request on the bus, waiting for rdy_ (or timeout)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int ADDR_W      = 30,
  parameter  int TIMEOUT_CYC = 255,
  localparam int BE_W        = DATA_W / 8,
  localparam int OFF_W       = $clog2(BE_W)
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    ex_en,
  input  logic [3:0]              ex_mem_op,
  input  logic [DATA_W-1:0]       ex_mem_wr_data,
  input  logic [ADDR_W+OFF_W-1:0] ex_out,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    rdy_,
  output logic [ADDR_W-1:0]       addr,
  output logic                    as_,
  output logic                    rw,
  output logic [BE_W-1:0]         be_,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    stall,
  output logic [DATA_W-1:0]       mem_out,
  output logic                    mem_en,
  output logic                    miss_align,
  output logic                    bus_err
);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic              dropped_q;
  logic [3:0]        op_sel;
  logic [OFF_W-1:0]  off_sel;
  logic              al_is_mem, al_is_load, al_mis;
  logic [BE_W-1:0]   al_be_;
  logic [DATA_W-1:0] al_wr_data, al_ld_data;
  logic              accept, complete, timeout, tmo_hit;

  // While on the bus, lane select must follow the accepted op, not EX/MEM.
  assign op_sel  = (state_q == BUS) ? op_q  : ex_mem_op;
  assign off_sel = (state_q == BUS) ? off_q : ex_out[OFF_W-1:0];

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op         (op_sel),
    .offset     (off_sel),
    .st_data    (ex_mem_wr_data),
    .rd_data    (rd_data),
    .is_mem     (al_is_mem),
    .is_load    (al_is_load),
    .misaligned (al_mis),
    .be_        (al_be_),
    .wr_data    (al_wr_data),
    .ld_data    (al_ld_data)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                                wait_cnt <= '0;
    else if (accept)                            wait_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    else if (state_q == BUS && wait_cnt != '0)  wait_cnt <= wait_cnt - CNT_W'(1);
  end

  assign tmo_hit = (wait_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_en && !flush && al_is_mem && !al_mis) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (!rdy_) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      addr       <= '0;
      as_        <= DISABLE_;
      rw         <= READ;
      be_        <= '1;
      wr_data    <= '0;
      mem_out    <= '0;
      mem_en     <= 1'b0;
      miss_align <= 1'b0;
      bus_err    <= 1'b0;
      op_q       <= OP_NOP;
      off_q      <= '0;
      dropped_q  <= 1'b0;
    end else begin
      miss_align <= 1'b0;
      bus_err    <= 1'b0;
      mem_en     <= 1'b0;
      if (state_q == IDLE) begin
        if (!ex_en || !al_is_mem) begin
          mem_out <= DATA_W'(ex_out);
          mem_en  <= ex_en & ~flush;
        end else if (!flush && al_mis) begin
          miss_align <= 1'b1;
        end else if (accept) begin
          addr      <= ex_out[ADDR_W+OFF_W-1:OFF_W];
          as_       <= ENABLE_;
          rw        <= al_is_load ? READ : WRITE;
          be_       <= al_be_;
          wr_data   <= al_wr_data;
          op_q      <= ex_mem_op;
          off_q     <= ex_out[OFF_W-1:0];
          dropped_q <= 1'b0;
        end
      end else begin
        dropped_q <= dropped_q | flush;
        if (complete || timeout) begin
          as_       <= DISABLE_;
          be_       <= '1;
          dropped_q <= 1'b0;
        end
        if (complete) begin
          mem_out <= al_is_load ? al_ld_data : '0;
          mem_en  <= ~(dropped_q | flush);
        end
        if (timeout) bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions checked against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [31:0] ex_out;
  logic        flush;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [3:0]  be_;
  logic [31:0] wr_data;
  logic        stall;
  logic [31:0] mem_out;
  logic        mem_en;
  logic        miss_align;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(30), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_(reset_), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .flush(flush),
    .rd_data(rd_data), .rdy_(rdy_), .addr(addr), .as_(as_), .rw(rw),
    .be_(be_), .wr_data(wr_data), .stall(stall), .mem_out(mem_out),
    .mem_en(mem_en), .miss_align(miss_align), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Little-endian lane extract with sign/zero extension, by plain arithmetic.
  function automatic logic [31:0] ref_load(logic [31:0] rd, int off, int sz, bit sgn);
    longint unsigned v, span;
    span = 64'd1 << (8 * sz);
    v = (64'(rd) >> (8 * off)) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic go_idle();
    ex_en = 1'b0; ex_mem_op = 4'd0; flush = 1'b0; rdy_ = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] xo, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits, input bit en,
                        input bit fl_idle, input int fl_bus);
    bit          is_mem, is_ld, sgn, mis, acc, drop;
    int          sz, off;
    logic [31:0] exp_wr, exp_ld;
    logic [3:0]  exp_be;
    is_mem = (op >= 4'd1 && op <= 4'd8);
    is_ld  = op inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    sgn    = op inside {4'd3, 4'd5};
    sz     = (op inside {4'd3, 4'd4, 4'd7}) ? 1 : (op inside {4'd5, 4'd6, 4'd8}) ? 2 : 4;
    off    = int'(xo[1:0]);
    mis    = is_mem && (off % sz != 0);
    acc    = en && is_mem && !fl_idle && !mis;
    exp_be = 4'(~(((1 << sz) - 1) << off));
    exp_wr = (sz == 1) ? sd[7:0] * 32'h0101_0101 : (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    exp_ld = ref_load(rd, off, sz, sgn);
    drop   = (fl_bus >= 0) && (fl_bus <= waits);

    ex_en = en; ex_mem_op = op; ex_out = xo; ex_mem_wr_data = sd;
    flush = fl_idle; rdy_ = 1'b1; rd_data = $urandom;
    @(negedge clk);
    chk("stall_req", stall, acc);
    @(posedge clk); #1;
    flush = 1'b0;
    if (!en || !is_mem) begin
      chk("pass_out", mem_out, xo);
      chk("pass_en", mem_en, en && !fl_idle);
      chk("pass_as", as_, 1'b1);
      go_idle();
    end else if (fl_idle) begin
      chk("flush_en", mem_en, 1'b0);
      chk("flush_as", as_, 1'b1);
      chk("flush_mis", miss_align, 1'b0);
      go_idle();
    end else if (mis) begin
      chk("mis_pulse", miss_align, 1'b1);
      chk("mis_en", mem_en, 1'b0);
      chk("mis_as", as_, 1'b1);
      go_idle();
      @(posedge clk); #1;
      chk("mis_clear", miss_align, 1'b0);
    end else begin
      chk("req_as", as_, 1'b0);
      chk("req_addr", addr, xo[31:2]);
      chk("req_rw", rw, is_ld);
      chk("req_be", be_, exp_be);
      if (!is_ld) chk("req_wdata", wr_data, exp_wr);
      for (int w = 0; w <= waits; w++) begin
        rdy_    = (w == waits) ? 1'b0 : 1'b1;
        rd_data = (w == waits) ? rd : $urandom;
        flush   = (w == fl_bus);
        @(negedge clk);
        chk("bus_stall", stall, w < waits);
        chk("bus_as", as_, 1'b0);
        @(posedge clk); #1;
      end
      go_idle();
      chk("done_as", as_, 1'b1);
      chk("done_be", be_, 4'hF);
      chk("done_en", mem_en, !drop);
      chk("done_out", mem_out, is_ld ? exp_ld : 32'h0);
      chk("done_err", bus_err, 1'b0);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] xo;
    int          waits, fl_bus;

    reset_ = 1'b0; go_idle(); ex_out = '0; ex_mem_wr_data = '0; rd_data = '0;
    #12;
    chk("rst_as", as_, 1'b1);
    chk("rst_rw", rw, 1'b1);
    chk("rst_be", be_, 4'hF);
    chk("rst_addr", addr, 30'h0);
    chk("rst_wdata", wr_data, 32'h0);
    chk("rst_out", mem_out, 32'h0);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_mis", miss_align, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk); reset_ = 1'b1;
    @(posedge clk); #1;

    // LDB 0x103, immediate ready; STH 0x102 with 3 wait states
    run_op(4'd3, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b1, 1'b0, -1);
    run_op(4'd8, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3, 1'b1, 1'b0, -1);
    // misaligned LDW and LDHU
    run_op(4'd1, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b1, 1'b0, -1);
    run_op(4'd6, 32'h0000_0103, 32'h0, 32'h0, 0, 1'b1, 1'b0, -1);
    // passthrough, then flush during a bus wait
    run_op(4'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b1, 1'b0, -1);
    run_op(4'd1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 1);

    // async reset in the middle of a bus access
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h0000_0400; rdy_ = 1'b1;
    @(posedge clk); #1;
    chk("mid_as_before", as_, 1'b0);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst_as", as_, 1'b1);
    chk("mid_rst_en", mem_en, 1'b0);
    chk("mid_rst_be", be_, 4'hF);
    @(negedge clk); reset_ = 1'b1; go_idle();
    @(posedge clk); #1;
    run_op(4'd5, 32'h0000_0602, 32'h0, 32'h9ABC_0000, 1, 1'b1, 1'b0, -1);

`ifdef MEM_BUS_TIMEOUT_EN
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h0000_0040; rdy_ = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("tmo_stall", stall, c < 4);
      @(posedge clk); #1;
    end
    go_idle();
    chk("tmo_err", bus_err, 1'b1);
    chk("tmo_as", as_, 1'b1);
    chk("tmo_en", mem_en, 1'b0);
    @(posedge clk); #1;
    chk("tmo_err_clear", bus_err, 1'b0);
`endif

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 8));
      xo = $urandom;
      if ($urandom_range(0, 1) == 1) xo[1:0] = 2'b00;
      waits  = int'($urandom_range(0, 3));
      fl_bus = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, waits)) : -1;
      run_op(op, xo, $urandom, $urandom, waits, $urandom_range(0, 7) != 0,
             $urandom_range(0, 9) == 0, fl_bus);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised MEM-stage access controller; successor to the single-cycle word-only controller.
- Adds byte/halfword loads and stores with sign/zero extension, per-byte enables and a wait-state bus handshake (rdy_) via a small FSM.
- Owns the MEM/WB result register and stalls the pipeline while a bus access is outstanding.
- Sits between the EX/MEM pipeline register and the bus interface unit.

Parameters:
- DATA_W, 32, bus data width; 32 or 64 only. BE_W = DATA_W/8 and OFF_W = log2(BE_W) are derived.
- ADDR_W, 30, word address width driven on addr.
- TIMEOUT_CYC, 255, maximum wait cycles per access (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous reset, active-low
- ex_en  in  1  EX/MEM entry valid
- ex_mem_op  in  4  memory op code (see package)
- ex_mem_wr_data  in  DATA_W  store data, right-aligned
- ex_out  in  ADDR_W+OFF_W  ALU result (byte address or passthrough value)
- flush  in  1  discard the current/outstanding result
- rd_data  in  DATA_W  bus read data
- rdy_  in  1  bus ready, active-low
- addr  out  ADDR_W  word address (registered)
- as_  out  1  address strobe, active-low (registered)
- rw  out  1  READ=1 / WRITE=0 (registered)
- be_  out  BE_W  byte enables, active-low (registered)
- wr_data  out  DATA_W  lane-replicated store data (registered)
- stall  out  1  hold EX/MEM and earlier stages (combinational)
- mem_out  out  DATA_W  MEM/WB result
- mem_en  out  1  MEM/WB valid
- miss_align  out  1  misaligned-access exception, 1-cycle pulse
- bus_err  out  1  bus timeout pulse; tied 0 when the optional feature is off

Behaviour:
- Reset (async, reset_=0):
  - state=IDLE; as_=1, rw=READ, be_ all 1, addr=0, wr_data=0.
  - mem_out=0, mem_en=0, miss_align=0, bus_err=0.
  - An in-flight access is abandoned immediately.
- Byte order is little-endian: offset 0 maps to bits 7:0. offset = ex_out[OFF_W-1:0]; addr = ex_out[ADDR_W+OFF_W-1:OFF_W].
- Alignment rules:
  - Halfword requires offset[0]=0.
  - Word requires the offset to be word-aligned within the lane: offset[1:0]=0.
  - For DATA_W=64, offset[2] selects the upper or lower word lane.
- IDLE, ex_en=0 or non-memory op (NOP or any unlisted code):
  - Next edge: mem_out<=ex_out zero-extended, mem_en<=ex_en & ~flush. Latency 1; stall=0.
- IDLE, misaligned memory op:
  - No bus cycle. Next edge: miss_align<=1, mem_en<=0; stall=0.
- IDLE, aligned memory op with ex_en=1 and flush=0:
  - stall=1 in this cycle.
  - Next edge: addr, rw, be_, wr_data are registered; as_<=0; state->BUS.
- BUS:
  - stall = rdy_ (high while waiting).
  - Each edge where rdy_=0: as_<=1, be_<=all 1, state->IDLE.
    - Load: mem_out<=lane-selected data, sign-extended for LDB/LDH or zero-extended for LDBU/LDHU/LDW.
    - Store: mem_out<=0.
    - mem_en<=~dropped.
  - Minimum memory latency is 2 cycles: accept cycle plus one bus cycle.
- Store lane data:
  - Byte is replicated into every byte lane; halfword into every half lane.
  - be_ is low only for the addressed bytes.
- Flush:
  - In IDLE, flush suppresses the request.
  - In BUS, the access completes on the bus (cannot be aborted); the result is dropped (mem_en=0).
  - flush is latched into a dropped flag, which clears on return to IDLE.
- miss_align and bus_err are cleared on the next edge (single-cycle pulses).

Optional Feature:
- MEM_BUS_TIMEOUT_EN
- Defined:
  - A wait counter runs in BUS and is cleared on entry.
  - If rdy_ stays high for TIMEOUT_CYC consecutive cycles: as_<=1, be_<=all 1, state->IDLE, bus_err<=1 for one cycle, mem_en<=0, stall drops in the terminating cycle.
- Undefined: no counter; BUS waits indefinitely; bus_err is constant 0.

Decomposition:
- Shared package/header holds:
  - Op encodings: NOP=0, LDW=1, STW=2 (legacy codes kept), LDB=3, LDBU=4, LDH=5, LDHU=6, STB=7, STH=8.
  - READ/WRITE, ENABLE_/DISABLE_ and state encodings IDLE/BUS.
- One sub-module: mem_lane_align. It is purely combinational and covers:
  - load lane select plus extension;
  - store replication plus be_ generation;
  - the misalignment check.

Test Plan:
- LDB at byte addr 0x103; rd_data=0x80FF_1234, rdy_=0 at the first BUS cycle -> be_=4'b0111, mem_out=0xFFFF_FF80, mem_en=1, 2-cycle latency, stall high 1 cycle.
- STH at 0x102 with data 0x0000_ABCD, rdy_ held high 3 cycles -> wr_data=0xABCD_ABCD, be_=4'b0011, rw=WRITE, stall high 4 cycles, mem_out=0.
- LDW at 0x101 -> no as_ assertion, miss_align pulses 1 cycle, mem_en=0; LDHU at 0x103 -> miss_align pulse.
- Non-memory op with ex_out=0x1234_5678 -> mem_out=0x1234_5678 next cycle, stall=0; flush during a BUS wait -> access completes, mem_en=0.
- reset_ low mid-BUS -> as_=1 and mem_en=0 asynchronously; the next op after release starts from IDLE.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYC=4, rdy_ never asserted -> bus_err pulses after 4 BUS cycles, as_ returns high, stall released.
